// File: rtl/psum_accum_wb_if.sv
// rtl/psum_accum_wb_if.sv - Control, psum stream and PMEM port bundle for psum_accum_wb
interface psum_accum_wb_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 9
);
    logic                   start;
    logic [addr_w-1:0]      base_addr;
    logic                   in_valid;
    logic [col*psum_bw-1:0] in_data;
    logic                   in_ready;
    logic [col*psum_bw-1:0] mem_q;
    logic [col*psum_bw-1:0] mem_d;
    logic [addr_w-1:0]      mem_addr;
    logic                   mem_cen;
    logic                   mem_wen;
    logic                   busy;
    logic [3:0]             pass_idx;
    logic                   done;

    modport master (
        output start, base_addr, in_valid, in_data, mem_q,
        input  in_ready, mem_d, mem_addr, mem_cen, mem_wen, busy, pass_idx, done
    );

    modport slave (
        input  start, base_addr, in_valid, in_data, mem_q,
        output in_ready, mem_d, mem_addr, mem_cen, mem_wen, busy, pass_idx, done
    );
endinterface

// File: rtl/psum_accum_wb.sv
// rtl/psum_accum_wb.sv - Psum write-back/accumulate stage into PMEM (optional macro ACCUM_RELU_EN)
module psum_accum_wb #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int addr_w   = 9,
    parameter int NUM_OUT  = 16,
    parameter int NUM_PASS = 9
) (
    input logic            clk,
    input logic            reset,
    psum_accum_wb_if.slave wb
);
    localparam int VEC_W = col * psum_bw;
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_RD,
        S_ADD,
        S_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [addr_w-1:0]  base_q, base_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         pass_q, pass_d;
    logic [VEC_W-1:0]   hold_q, hold_d;
    logic [VEC_W-1:0]   sum_q, sum_d;

    logic               last_idx;
    logic               last_pass;
    logic [addr_w-1:0]  cur_addr;
    logic [VEC_W-1:0]   wr_data;

    // Position decode shared by next-state and output logic; address wraps modulo 2^addr_w
    always_comb begin
        last_idx  = (idx_q == IDX_W'(NUM_OUT - 1));
        last_pass = (pass_q == 4'(NUM_PASS - 1));
        cur_addr  = base_q + addr_w'(idx_q);
    end

`ifdef ACCUM_RELU_EN
    // Final pass clamps negative lanes to zero; earlier passes keep raw partial sums
    always_comb begin
        wr_data = sum_q;
        if (last_pass) begin
            for (int i = 0; i < col; i++) begin
                if (sum_q[psum_bw*i + psum_bw - 1]) begin
                    wr_data[psum_bw*i +: psum_bw] = '0;
                end
            end
        end
    end
`else
    // Every pass stores the raw wrapped sum
    always_comb begin
        wr_data = sum_q;
    end
`endif

    // State and datapath registers; reset aborts any sequence, PMEM is left untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            hold_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            hold_q  <= hold_d;
            sum_q   <= sum_d;
        end
    end

    // Sequencing: accept vector, optionally read-add, write back, advance idx/pass
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        hold_d  = hold_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (wb.start) begin
                    base_d  = wb.base_addr;
                    idx_d   = '0;
                    pass_d  = '0;
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (wb.in_valid) begin
                    hold_d = wb.in_data;
                    if (pass_q == 4'd0) begin
                        // First pass overwrites PMEM, no read needed
                        sum_d   = wb.in_data;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_ADD;
            end
            S_ADD: begin
                // Lane-wise signed add, wrapping modulo 2^psum_bw
                for (int i = 0; i < col; i++) begin
                    sum_d[psum_bw*i +: psum_bw] = wb.mem_q[psum_bw*i +: psum_bw]
                                                + hold_q[psum_bw*i +: psum_bw];
                end
                state_d = S_WR;
            end
            S_WR: begin
                if (!last_idx) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_WAIT_IN;
                end else if (!last_pass) begin
                    idx_d   = '0;
                    pass_d  = pass_q + 4'd1;
                    state_d = S_WAIT_IN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registers only, so a reset cycle never strobes PMEM
    always_comb begin
        wb.in_ready = 1'b0;
        wb.mem_cen  = 1'b1;
        wb.mem_wen  = 1'b1;
        wb.mem_addr = '0;
        wb.mem_d    = '0;
        wb.busy     = (state_q != S_IDLE);
        wb.done     = 1'b0;
        wb.pass_idx = pass_q;
        case (state_q)
            S_WAIT_IN: begin
                wb.in_ready = 1'b1;
            end
            S_RD: begin
                wb.mem_cen  = 1'b0;
                wb.mem_addr = cur_addr;
            end
            S_WR: begin
                wb.mem_cen  = 1'b0;
                wb.mem_wen  = 1'b0;
                wb.mem_addr = cur_addr;
                wb.mem_d    = wr_data;
            end
            S_DONE: begin
                wb.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_psum_accum_wb.sv
// tb/tb_psum_accum_wb.sv - Self-checking bench for psum_accum_wb with PMEM model
module tb_psum_accum_wb;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 9;
    localparam int NO  = 16;
    localparam int NP  = 9;
    localparam int VW  = COL * BW;

    logic clk;
    logic resetn;

    int n_checks = 0;
    int n_err    = 0;

    psum_accum_wb_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) wbif ();

    psum_accum_wb #(
        .col(COL), .psum_bw(BW), .addr_w(AW), .NUM_OUT(NO), .NUM_PASS(NP)
    ) u_dut (
        .clk   (clk),
        .reset (resetn),
        .wb    (wbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [VW-1:0] pmem [0:(1<<AW)-1];
    logic [VW-1:0] vecs [0:NP-1][0:NO-1];
    logic [AW-1:0] wlog [0:4095];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_p0_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (!wbif.mem_cen) begin
            if (!wbif.mem_wen) pmem[wbif.mem_addr] <= wbif.mem_d;
            else               wbif.mem_q <= pmem[wbif.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (!wbif.mem_cen && !wbif.mem_wen) begin
                wlog[wr_cnt[11:0]] <= wbif.mem_addr;
                wr_cnt <= wr_cnt + 1;
            end
            if (!wbif.mem_cen && wbif.mem_wen) begin
                rd_cnt <= rd_cnt + 1;
                if (wbif.pass_idx == 4'd0) rd_p0_cnt <= rd_p0_cnt + 1;
            end
            if (wbif.done) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Final PMEM content: total of all passes, wrapped to psum_bw, clamped on final write if ReLU
    function automatic logic [VW-1:0] expect_final(input int n);
        logic [VW-1:0] r;
        int s;
        for (int l = 0; l < COL; l++) begin
            s = 0;
            for (int p = 0; p < NP; p++) s += int'($signed(vecs[p][n][BW*l +: BW]));
            r[BW*l +: BW] = 16'(s);
`ifdef ACCUM_RELU_EN
            if (r[BW*l + BW - 1]) r[BW*l +: BW] = '0;
`endif
        end
        return r;
    endfunction

    task automatic pulse_start(input logic [AW-1:0] b);
        wbif.start = 1'b1;
        wbif.base_addr = b;
        @(negedge clk);
        wbif.start = 1'b0;
        check("start_busy", VW'(wbif.busy), VW'(1));
        check("start_pass_idx", VW'(wbif.pass_idx), VW'(0));
    endtask

    // Starts and ends at a negedge; holds in_valid low for 'stall' WAIT_IN cycles first
    task automatic send_vec(input logic [VW-1:0] d, input int stall, input int p);
        int t;
        int w0;
        t = 0;
        while (wbif.in_ready !== 1'b1 && t <= 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", VW'(wbif.in_ready), VW'(1));
        w0 = wr_cnt;
        for (int s = 0; s < stall; s++) begin
            check($sformatf("stall%0d_ready", s), VW'(wbif.in_ready), VW'(1));
            check($sformatf("stall%0d_cen", s), VW'(wbif.mem_cen), VW'(1));
            check($sformatf("stall%0d_pass", s), VW'(wbif.pass_idx), VW'(p));
            @(negedge clk);
        end
        if (stall > 0) check("stall_no_write", VW'(wr_cnt), VW'(w0));
        wbif.in_valid = 1'b1;
        wbif.in_data = d;
        @(negedge clk);
        wbif.in_valid = 1'b0;
        wbif.in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_seq(input logic [AW-1:0] base, input bit perturb);
        int wr0, rd0, rdp0, dn0, t;
        logic [AW-1:0] ea;
        wr0 = wr_cnt; rd0 = rd_cnt; rdp0 = rd_p0_cnt; dn0 = done_cnt;
        pulse_start(base);
        for (int p = 0; p < NP; p++) begin
            for (int n = 0; n < NO; n++) begin
                if (perturb && p == 4 && n == 3) begin
                    wbif.start = 1'b1;
                    wbif.base_addr = ~base;
                    @(negedge clk);
                    wbif.start = 1'b0;
                    wbif.base_addr = base;
                    check("ignored_start_pass", VW'(wbif.pass_idx), VW'(4));
                end
                send_vec(vecs[p][n], (perturb && p == 2 && n == 5) ? 5 : int'($urandom_range(0, 2)), p);
            end
        end
        t = 0;
        while (wbif.done !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", VW'(wbif.done), VW'(1));
        check("busy_in_done", VW'(wbif.busy), VW'(1));
        @(negedge clk);
        check("done_one_cycle", VW'(wbif.done), VW'(0));
        check("busy_after_done", VW'(wbif.busy), VW'(0));
        check("idle_cen", VW'(wbif.mem_cen), VW'(1));
        check("done_count", VW'(done_cnt - dn0), VW'(1));
        check("write_count", VW'(wr_cnt - wr0), VW'(NP * NO));
        check("read_count", VW'(rd_cnt - rd0), VW'((NP - 1) * NO));
        check("reads_in_pass0", VW'(rd_p0_cnt - rdp0), VW'(0));
        for (int k = 0; k < NP * NO; k++) begin
            ea = base + AW'(k % NO);
            check($sformatf("waddr_%0d", k), VW'(wlog[(wr0 + k) % 4096]), VW'(ea));
        end
        for (int n = 0; n < NO; n++) begin
            ea = base + AW'(n);
            check($sformatf("pmem_idx%0d", n), pmem[ea], expect_final(n));
        end
    endtask

    initial begin
        logic [AW-1:0] b;
        logic [VW-1:0] v;
        int w0, r0;
        resetn = 1'b0;
        wbif.start = 1'b0;
        wbif.base_addr = '0;
        wbif.in_valid = 1'b0;
        wbif.in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", VW'(wbif.in_ready), VW'(0));
        check("rst_cen", VW'(wbif.mem_cen), VW'(1));
        check("rst_wen", VW'(wbif.mem_wen), VW'(1));
        check("rst_addr", VW'(wbif.mem_addr), VW'(0));
        check("rst_d", wbif.mem_d, VW'(0));
        check("rst_busy", VW'(wbif.busy), VW'(0));
        check("rst_done", VW'(wbif.done), VW'(0));
        check("rst_pass_idx", VW'(wbif.pass_idx), VW'(0));
        resetn = 1'b1;
        @(negedge clk);

        // All-ones accumulation: every lane ends at NUM_PASS
        for (int p = 0; p < NP; p++)
            for (int n = 0; n < NO; n++)
                vecs[p][n] = {COL{16'h0001}};
        run_seq(9'h010, 1'b0);
        check("ones_lane9", pmem[9'h01F], {COL{16'h0009}});

        // Random data with wrap corners, address wrap, stall and ignored start
        for (int p = 0; p < NP; p++)
            for (int n = 0; n < NO; n++)
                vecs[p][n] = {$urandom, $urandom, $urandom, $urandom};
        for (int p = 0; p < NP; p++) begin
            v = vecs[p][0];
            v[15:0] = (p == 0) ? 16'h7FFF : ((p == 1) ? 16'h0001 : 16'h0000);
            vecs[p][0] = v;
            v = vecs[p][1];
            v[15:0]  = (p == NP - 1) ? 16'hFFFB : 16'h0000;
            v[31:16] = (p == NP - 1) ? 16'h0007 : 16'h0000;
            vecs[p][1] = v;
        end
        run_seq(9'h1FA, 1'b1);
        v = pmem[9'h1FA];
`ifdef ACCUM_RELU_EN
        check("wrap_7fff_plus1", VW'(v[15:0]), VW'(16'h0000));
`else
        check("wrap_7fff_plus1", VW'(v[15:0]), VW'(16'h8000));
`endif
        v = pmem[9'h1FB];
`ifdef ACCUM_RELU_EN
        check("final_neg5", VW'(v[15:0]), VW'(16'h0000));
`else
        check("final_neg5", VW'(v[15:0]), VW'(16'hFFFB));
`endif
        check("final_pos7", VW'(v[31:16]), VW'(16'h0007));

        // Reset during the read strobe of pass 3, then restart
        for (int p = 0; p < NP; p++)
            for (int n = 0; n < NO; n++)
                vecs[p][n] = {$urandom, $urandom, $urandom, $urandom};
        b = AW'($urandom_range(0, 511));
        pulse_start(b);
        for (int p = 0; p < 3; p++)
            for (int n = 0; n < NO; n++)
                send_vec(vecs[p][n], 0, p);
        send_vec(vecs[3][0], 0, 3);
        check("rd_state_cen", VW'(wbif.mem_cen), VW'(0));
        check("rd_state_wen", VW'(wbif.mem_wen), VW'(1));
        check("rd_state_pass", VW'(wbif.pass_idx), VW'(3));
        w0 = wr_cnt;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cen", VW'(wbif.mem_cen), VW'(1));
        check("midrst_wen", VW'(wbif.mem_wen), VW'(1));
        check("midrst_busy", VW'(wbif.busy), VW'(0));
        check("midrst_pass", VW'(wbif.pass_idx), VW'(0));
        check("midrst_ready", VW'(wbif.in_ready), VW'(0));
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_write", VW'(wr_cnt), VW'(w0));
        r0 = rd_cnt;
        pulse_start(b);
        send_vec(vecs[NP-1][0], 0, 0);
        repeat (2) @(negedge clk);
        check("restart_write", VW'(wr_cnt), VW'(w0 + 1));
        check("restart_no_read", VW'(rd_cnt), VW'(r0));
        check("restart_data", pmem[b], vecs[NP-1][0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
